// File: rtl/ones_frame_tx_if.sv
// ones_frame_tx_if: request/response bundle for the thermometer frame
// transmitter.
//   start, count      : request side, driven by the producer (master)
//   ready             : transmitter idle, can take a request
//   frame [0:14]      : parallel thermometer frame of the last accepted count
//   sout, sout_valid  : serial bit stream, bit 0 first
//   done              : one-cycle pulse after the last serial bit
interface ones_frame_tx_if;
  logic        start;
  logic [3:0]  count;
  logic        ready;
  logic [0:14] frame;
  logic        sout;
  logic        sout_valid;
  logic        done;

  modport master (
    output start, count,
    input  ready, frame, sout, sout_valid, done
  );

  modport slave (
    input  start, count,
    output ready, frame, sout, sout_valid, done
  );
endinterface

// File: rtl/ones_frame_tx.sv
// ones_frame_tx: encodes a 4-bit ones-count as a 15-bit thermometer frame
// (bits 0..count-1 set), holds it in a parallel register and shifts it out
// serially, bit 0 first. The far end recovers the count with a ones-counter.
//
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : ones_frame_tx_if.slave (start, count, ready, frame, sout,
//           sout_valid, done)
//
// Parameter IDLE_LEVEL: level on sout whenever sout_valid=0.
//
// Build option: define ONES_FRAME_PARITY_BIT_EN to append one even-parity
// bit (= count[0]) after bit 14; the frame period then grows from 17 to 18.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | ready=1, waiting for start; frame holds the last accepted value
// SHIFT | sout_valid=1, sending frame[idx] (idx 15 = parity when enabled)
// DONE  | done=1 for one cycle, then back to IDLE
module ones_frame_tx #(
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  ones_frame_tx_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

`ifdef ONES_FRAME_PARITY_BIT_EN
  localparam logic [3:0] LAST_IDX = 4'd15;
`else
  localparam logic [3:0] LAST_IDX = 4'd14;
`endif

  state_t      state, state_nxt;
  logic [3:0]  idx, idx_nxt;
  logic [0:14] frame_q, frame_nxt;
  logic        ready_q, ready_nxt;
  logic        sout_q, sout_nxt;
  logic        valid_q, valid_nxt;
  logic        done_q, done_nxt;

  function automatic logic [0:14] thermo(input logic [3:0] c);
    logic [0:14] t;
    for (int i = 0; i < 15; i++) t[i] = (4'(i) < c);
    return t;
  endfunction

  // Index 15 exists only in the parity build; XOR of a thermometer frame
  // is count[0], which makes the 16-bit stream even parity.
  function automatic logic bit_at(input logic [0:14] f, input logic [3:0] i);
`ifdef ONES_FRAME_PARITY_BIT_EN
    if (i == 4'd15) return ^f;
`endif
    return f[i];
  endfunction

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    frame_nxt = frame_q;
    ready_nxt = 1'b0;
    sout_nxt  = IDLE_LEVEL;
    valid_nxt = 1'b0;
    done_nxt  = 1'b0;

    case (state)
      IDLE: begin
        if (bus.start) begin
          frame_nxt = thermo(bus.count);
          idx_nxt   = 4'd0;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (idx == LAST_IDX) state_nxt = DONE;
        else                 idx_nxt   = idx + 4'd1;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    // Outputs are computed from the next state so they can be registered
    // without adding a cycle of latency.
    case (state_nxt)
      IDLE:  ready_nxt = 1'b1;
      SHIFT: begin
        valid_nxt = 1'b1;
        sout_nxt  = bit_at(frame_nxt, idx_nxt);
      end
      DONE:  done_nxt = 1'b1;
      default: ready_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      idx     <= 4'd0;
      frame_q <= '0;
      ready_q <= 1'b1;
      sout_q  <= IDLE_LEVEL;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      idx     <= idx_nxt;
      frame_q <= frame_nxt;
      ready_q <= ready_nxt;
      sout_q  <= sout_nxt;
      valid_q <= valid_nxt;
      done_q  <= done_nxt;
    end
  end

  assign bus.ready      = ready_q;
  assign bus.frame      = frame_q;
  assign bus.sout       = sout_q;
  assign bus.sout_valid = valid_q;
  assign bus.done       = done_q;

endmodule
